// File: rtl/execute_hazard_controller_if.sv
// Decode-side hazard inputs and execute-stage control outputs of the hazard controller.
// The controller uses the slave view. The driver of the decode fields uses the master view.
interface execute_hazard_controller_if #(
  parameter int CNT_BITS = 16
);
  logic [3:0]          RA1D;
  logic [3:0]          RA2D;
  logic [3:0]          WA4D;
  logic                RegWriteD;
  logic                MemtoRegD;
  logic                BranchTakenE;
  logic                CntClr;
  logic [1:0]          ForwardAE;
  logic [1:0]          ForwardBE;
  logic                StallF;
  logic                StallD;
  logic                FlushD;
  logic                FlushE;
  logic [CNT_BITS-1:0] StallCount;
  logic [CNT_BITS-1:0] FlushCount;

  modport master (
    output RA1D, RA2D, WA4D, RegWriteD, MemtoRegD, BranchTakenE, CntClr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, WA4D, RegWriteD, MemtoRegD, BranchTakenE, CntClr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );
endinterface

// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard unit: E/M/W destination shadows, operand forwarding selects,
// load-use stall, branch flush and saturating stall/flush event counters.
module execute_hazard_controller #(
  parameter int         CNT_BITS = 16,
  parameter logic [3:0] PC_REG   = 4'd15
) (
  input  logic                          CLK,
  input  logic                          RST,
  execute_hazard_controller_if.slave    hz
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [3:0]          ra1_e_q, ra1_e_d;
  logic [3:0]          ra2_e_q, ra2_e_d;
  logic [3:0]          wa4_e_q, wa4_e_d;
  logic                rw_e_q, rw_e_d;
  logic                mtr_e_q, mtr_e_d;
  logic [3:0]          wa4_m_q;
  logic                rw_m_q;
  logic [3:0]          wa4_w_q;
  logic                rw_w_q;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic                ld_stall;
  logic                flush_e;

  // M holds the newest result, so it wins over W; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       rw_m,
                                         input logic [3:0] wa_m,
                                         input logic       rw_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_REG) begin
      if (rw_m && (wa_m == ra))      sel = 2'b10;
      else if (rw_w && (wa_w == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ld_stall = mtr_e_q && rw_e_q &&
               ((wa4_e_q == hz.RA1D) || (wa4_e_q == hz.RA2D)) && !hz.BranchTakenE;
    flush_e  = ld_stall || hz.BranchTakenE;
  end

  always_comb begin
    ra1_e_d = hz.RA1D;
    ra2_e_d = hz.RA2D;
    wa4_e_d = hz.WA4D;
    rw_e_d  = hz.RegWriteD;
    mtr_e_d = hz.MemtoRegD;
    if (flush_e) begin
      ra1_e_d = 4'd0;
      ra2_e_d = 4'd0;
      wa4_e_d = 4'd0;
      rw_e_d  = 1'b0;
      mtr_e_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (ld_stall && (stall_cnt_q != '1))        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (hz.BranchTakenE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ra1_e_q     <= 4'd0;
      ra2_e_q     <= 4'd0;
      wa4_e_q     <= 4'd0;
      rw_e_q      <= 1'b0;
      mtr_e_q     <= 1'b0;
      wa4_m_q     <= 4'd0;
      rw_m_q      <= 1'b0;
      wa4_w_q     <= 4'd0;
      rw_w_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ra1_e_q     <= ra1_e_d;
      ra2_e_q     <= ra2_e_d;
      wa4_e_q     <= wa4_e_d;
      rw_e_q      <= rw_e_d;
      mtr_e_q     <= mtr_e_d;
      wa4_m_q     <= wa4_e_q;
      rw_m_q      <= rw_e_q;
      wa4_w_q     <= wa4_m_q;
      rw_w_q      <= rw_m_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.ForwardAE  = fwd_sel(ra1_e_q, rw_m_q, wa4_m_q, rw_w_q, wa4_w_q);
  assign hz.ForwardBE  = fwd_sel(ra2_e_q, rw_m_q, wa4_m_q, rw_w_q, wa4_w_q);
  assign hz.StallF     = ld_stall;
  assign hz.StallD     = ld_stall;
  assign hz.FlushD     = hz.BranchTakenE;
  assign hz.FlushE     = flush_e;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Scoreboard bench for execute_hazard_controller: directed decode vectors push expected
// outputs into a queue, a negedge monitor pops and compares. Counters are 8 bits here so saturation is reachable.
module tb_execute_hazard_controller;

  localparam int CB = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  execute_hazard_controller_if #(.CNT_BITS(CB)) hz ();

  execute_hazard_controller #(.CNT_BITS(CB), .PC_REG(4'd15)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  typedef struct {
    string         name;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          sf;
    logic          sd;
    logic          fd;
    logic          fe;
    logic [CB-1:0] sc;
    logic [CB-1:0] fc;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [CB-1:0] exp_sc = '0;
  logic [CB-1:0] exp_fc = '0;
  localparam logic [CB-1:0] ONE = CB'(1);

  // Monitor: one scoreboard entry per falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE,
           hz.StallCount, hz.FlushCount} !==
          {e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.sc, e.fc}) begin
        n_errors++;
        $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0h fc=%0h, want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0h fc=%0h",
                 e.name, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE,
                 hz.StallCount, hz.FlushCount, e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.sc, e.fc);
      end
    end
  end

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa4,
                       input logic rw, input logic mtr, input logic br, input logic clr);
    hz.RA1D         = ra1;
    hz.RA2D         = ra2;
    hz.WA4D         = wa4;
    hz.RegWriteD    = rw;
    hz.MemtoRegD    = mtr;
    hz.BranchTakenE = br;
    hz.CntClr       = clr;
  endtask

  task automatic push_exp(input string nm, input logic [1:0] efa, input logic [1:0] efb,
                          input logic es, input logic br);
    exp_t e;
    e.name = nm;
    e.fa   = efa;
    e.fb   = efb;
    e.sf   = es;
    e.sd   = es;
    e.fd   = br;
    e.fe   = es | br;
    e.sc   = exp_sc;
    e.fc   = exp_fc;
    sb.push_back(e);
  endtask

  // One decode cycle: drive D, record expected outputs for this cycle, then the counter values after the edge.
  task automatic step(input string nm, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa4, input logic rw, input logic mtr,
                      input logic br, input logic clr,
                      input logic [1:0] efa, input logic [1:0] efb, input logic es);
    @(posedge CLK);
    #1;
    drive(ra1, ra2, wa4, rw, mtr, br, clr);
    push_exp(nm, efa, efb, es, br);
    if (clr) begin
      exp_sc = '0;
      exp_fc = '0;
    end else begin
      if (es && (exp_sc != '1)) exp_sc = exp_sc + ONE;
      if (br && (exp_fc != '1)) exp_fc = exp_fc + ONE;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    push_exp("reset_state", 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge CLK);
    #1 RST = 1'b1;

    //   name          ra1   ra2   wa4   rw    mtr   br    clr   fa     fb     stall
    step("m_c1",       4'd1, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("m_c2",       4'd3, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("m_fwd_a",    4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
    step("m_c4",       4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("m_c5",       4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("w_c6",       4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("w_c7",       4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("w_c8",       4'd9, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("w_fwd_b",    4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
    step("p_c10",      4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("p_c11",      4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("p_c12",      4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("mw_prio_b",  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
    step("pc_c14",     4'd0, 4'd0, 4'd15,1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("pc_c15",     4'd15,4'd15,4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("pc_no_fwd",  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("pc_c17",     4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_load",    4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_stall",   4'd2, 4'd0, 4'd10,1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    step("lu_release", 4'd2, 4'd0, 4'd10,1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_w_fwd",   4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    step("br_load",    4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("br_wins",    4'd0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    step("br_after",   4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Repeated load-use hazards drive StallCount into saturation.
    for (int i = 0; i < 256; i++) begin
      step("sat_load",  4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0,
           (i == 0) ? 2'b00 : 2'b01, 2'b00, 1'b0);
      step("sat_stall", 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      step("sat_hold",  4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    end

    step("clr_with_br",4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
    step("after_clr",  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("pre_rst_ld", 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Async reset while a load-use stall is active: outputs must drop before any edge.
    @(posedge CLK);
    #1;
    drive(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 RST = 1'b0;
    exp_sc = '0;
    exp_fc = '0;
    push_exp("reset_mid_stall", 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge CLK);
    #2;
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;

    step("post_rst_w", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("post_rst_r", 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("post_rst_fb",4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);

    repeat (2) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_hazard_controller.md
Name: execute_hazard_controller

Overview:
- Hazard and sequencing controller for the execute stage of the pipelined datapath.
- Tracks destination registers of in-flight instructions in internal E/M/W shadow registers.
- Drives the forwarding selects for the ALU operand muxes (SrcA/SrcB), load-use stalls of the F/D stages, and D/E flushes on taken branches.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- CNT_BITS, 16, width of the stall and flush event counters.
- PC_REG, 4'd15, register index never forwarded (PC).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low (RST=0 resets).
- RA1D  input  4  source register 1 of the instruction in decode.
- RA2D  input  4  source register 2 of the instruction in decode.
- WA4D  input  4  destination register of the instruction in decode.
- RegWriteD  input  1  decode instruction writes the register file.
- MemtoRegD  input  1  decode instruction is a load.
- BranchTakenE  input  1  branch in execute resolved taken this cycle.
- CntClr  input  1  synchronous clear of both counters.
- ForwardAE  output  2  SrcA select: 00 = RD1, 01 = W result, 10 = M ALU result.
- ForwardBE  output  2  SrcB select, same encoding as ForwardAE.
- StallF  output  1  hold fetch PC register.
- StallD  output  1  hold decode pipeline register.
- FlushD  output  1  clear decode pipeline register.
- FlushE  output  1  clear execute pipeline register (bubble).
- StallCount  output  CNT_BITS  number of load-use stall cycles.
- FlushCount  output  CNT_BITS  number of taken-branch flush events.

Behaviour:
- Shadow pipeline:
  - E regs (RA1E, RA2E, WA4E, RegWriteE, MemtoRegE) load from the D inputs each cycle.
  - If FlushE=1, the E regs load a bubble instead: RegWriteE=0, MemtoRegE=0, all addresses 0.
  - M regs (WA4M, RegWriteM) load from E each cycle.
  - W regs (WA4W, RegWriteW) load from M each cycle.
- Forwarding (combinational from the E/M/W regs), shown for A; B is identical using RA2E:
  - 10 if RegWriteM && WA4M==RA1E && RA1E!=PC_REG.
  - else 01 if RegWriteW && WA4W==RA1E && RA1E!=PC_REG.
  - else 00.
  - When M and W both match, M has priority (newest value).
- Load-use stall:
  - LdStall = MemtoRegE && RegWriteE && (WA4E==RA1D || WA4E==RA2D) && !BranchTakenE.
  - StallF = StallD = LdStall.
  - Exactly one stall cycle per hazard: the bubble inserted in E clears MemtoRegE on the next edge.
- Flush:
  - FlushD = BranchTakenE.
  - FlushE = LdStall | BranchTakenE.
  - Branch-taken and a load-use match in the same cycle: branch wins, no stall, D and E flushed.
- Outputs are combinational from state and inputs; no added latency. Forwarding applies in the same cycle as the matching E instruction.
- Counters:
  - StallCount increments on each cycle with LdStall=1.
  - FlushCount increments on each cycle with BranchTakenE=1.
  - Both saturate at all-ones.
  - CntClr has priority over increment; when CntClr=1, the next value is 0.
- Reset (RST=0, any time, including mid-stall): all shadow regs and counters go to 0 immediately, so all outputs read 0. The first edge after RST rises resumes normal behaviour with an empty pipeline.

Test Plan:
- Reset mid-stall: assert RST=0 during an active LdStall -> StallF/StallD/FlushE/ForwardAE/ForwardBE=0 and both counters=0 immediately, without waiting for a clock edge.
- M forwarding: ADD writes R3 (RegWriteD=1, WA4D=3), then next instruction reads RA1D=3 -> when the reader is in E, ForwardAE=10, ForwardBE=00.
- W forwarding and priority:
  - Writer to R5, one unrelated instruction, then reader RA2D=5 -> ForwardBE=01.
  - With writes to R5 in both M and W -> ForwardBE=10.
- PC exclusion: writer WA4D=15 followed by reader RA1D=15 -> ForwardAE stays 00.
- Load-use: load (MemtoRegD=1, WA4D=2) followed by reader RA1D=2 -> exactly one cycle of StallF=StallD=FlushE=1, then ForwardAE=01 on the following E cycle; StallCount=1.
- Branch plus counters: BranchTakenE=1 together with a load-use match -> StallF=0, FlushD=FlushE=1, FlushCount increments.
- Counter saturation and clear: preload StallCount to FFFF, trigger another stall -> StallCount holds FFFF; CntClr=1 -> 0 on the next edge.
